// File: rtl/data_gen_pkg.sv
// Shared constants for the seven-segment test-pattern source (data_gen).
package data_gen_pkg;

    // Datapath and counter widths
    localparam int DATA_W = 20;
    localparam int CNT_W  = 23;
    localparam int DIG_N  = 6;

    // Default prescaler terminal value: 100 ms at 50 MHz is 5_000_000 cycles
    localparam logic [CNT_W-1:0]  CNT_100MS_DEF = 23'd4_999_999;

    // Default largest displayed value (six decimal digits)
    localparam logic [DATA_W-1:0] DATA_MAX_DEF  = 20'd999_999;

    // Decimal-point mask with no point lit
    localparam logic [DIG_N-1:0]  POINT_NONE    = 6'b000000;

endpackage

// File: rtl/data_gen_tick.sv
// Prescaler for data_gen: counts 0..CNT_MAX and pulses tick for one cycle
// while the count sits at CNT_MAX. CNT_MAX = 0 gives a tick every cycle.
module data_gen_tick #(
    parameter int               CNT_W   = 23,
    parameter logic [CNT_W-1:0] CNT_MAX = '1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal-count detect and wrap-to-zero next-state logic
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Prescaler count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_gen.sv
// data_gen: test-pattern source for the 6-digit seven-segment display path.
// Emits a value that steps once per prescaler period and wraps at DATA_MAX,
// plus a fixed decimal-point mask, a sign flag and a display enable.
// Build option: define DATA_GEN_SIGN_EN to make sign toggle on every
// DATA_MAX -> 0 wrap; without it sign is a constant 0 and no flop is built.
module data_gen
    import data_gen_pkg::*;
#(
    parameter logic [CNT_W-1:0]  CNT_100MS = CNT_100MS_DEF,
    parameter logic [DATA_W-1:0] DATA_MAX  = DATA_MAX_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    output logic [DATA_W-1:0] data,
    output logic [DIG_N-1:0]  point,
    output logic              sign,
    output logic              seg_en
);

    logic              tick;
    logic              wrap;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [DIG_N-1:0]  point_q;
    logic [DIG_N-1:0]  point_d;
    logic              seg_en_q;
    logic              seg_en_d;

    data_gen_tick #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_100MS)
    ) u_tick (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .tick  (tick)
    );

    // Next-state logic: step data on tick with equality wrap; constants for the rest
    always_comb begin
        wrap     = tick && (data_q == DATA_MAX);
        data_d   = data_q;
        if (tick) begin
            data_d = wrap ? '0 : data_q + 1'b1;
        end
        point_d  = POINT_NONE;
        seg_en_d = 1'b1;
    end

    // Output registers; seg_en rises on the first edge after reset release
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_q   <= '0;
            point_q  <= POINT_NONE;
            seg_en_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            point_q  <= point_d;
            seg_en_q <= seg_en_d;
        end
    end

`ifdef DATA_GEN_SIGN_EN
    logic sign_q;
    logic sign_d;

    // Sign flips on the same edge that wraps data back to zero
    always_comb begin
        sign_d = wrap ? ~sign_q : sign_q;
    end

    // Sign register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
        end
    end

    assign sign = sign_q;
`else
    assign sign = 1'b0;
`endif

    assign data   = data_q;
    assign point  = point_q;
    assign seg_en = seg_en_q;

endmodule

// File: tb/tb_data_gen.sv
// Bench for data_gen. Two instances share clock and reset: a slow one
// (CNT_100MS = 9, DATA_MAX = 9) and a fast one (CNT_100MS = 0, DATA_MAX = 9).
// The reference model counts rising edges since the last reset release and
// derives every output arithmetically from that count.
module tb_data_gen;

    localparam int SLOW_PER = 10;  // CNT_100MS + 1 for the slow instance
    localparam int FAST_PER = 1;   // CNT_100MS + 1 for the fast instance
    localparam int NVAL     = 10;  // DATA_MAX + 1

    logic        clk;
    logic        rst_n;
    logic [19:0] s_data, f_data;
    logic [5:0]  s_point, f_point;
    logic        s_sign, f_sign;
    logic        s_seg_en, f_seg_en;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;   // rising edges seen since reset release

    data_gen #(.CNT_100MS(23'd9), .DATA_MAX(20'd9)) dut_slow (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .data      (s_data),
        .point     (s_point),
        .sign      (s_sign),
        .seg_en    (s_seg_en)
    );

    data_gen #(.CNT_100MS(23'd0), .DATA_MAX(20'd9)) dut_fast (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .data      (f_data),
        .point     (f_point),
        .sign      (f_sign),
        .seg_en    (f_seg_en)
    );

    initial clk = 1'b1;
    always #10 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_data(input int n, input int per);
        return (n / per) % NVAL;
    endfunction

    function automatic int exp_sign(input int n, input int per);
`ifdef DATA_GEN_SIGN_EN
        return (n / (per * NVAL)) % 2;
`else
        return 0;
`endif
    endfunction

    // Edge counter of the reference model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // Continuous comparison against the model on every falling edge
    always @(negedge clk) begin
        check("s_data",   int'(s_data),   exp_data(edges, SLOW_PER));
        check("f_data",   int'(f_data),   exp_data(edges, FAST_PER));
        check("s_sign",   int'(s_sign),   exp_sign(edges, SLOW_PER));
        check("f_sign",   int'(f_sign),   exp_sign(edges, FAST_PER));
        check("s_point",  int'(s_point),  0);
        check("f_point",  int'(f_point),  0);
        check("s_seg_en", int'(s_seg_en), (edges >= 1) ? 1 : 0);
        check("f_seg_en", int'(f_seg_en), (edges >= 1) ? 1 : 0);
    end

    initial begin
        logic prev_sign;
        rst_n = 1'b0;
        #5;
        check("rst_data",   int'(s_data),   0);
        check("rst_point",  int'(s_point),  0);
        check("rst_sign",   int'(s_sign),   0);
        check("rst_seg_en", int'(s_seg_en), 0);
        #25 rst_n = 1'b1;   // release at 30 ns, between edges

        // First edge after release: display enabled, data unchanged
        @(posedge clk); #1;
        check("first_seg_en", int'(s_seg_en), 1);
        check("first_data",   int'(s_data),   0);
        check("fast_step1",   int'(f_data),   1);
        repeat (8) @(posedge clk);
        #1 check("pre_step", int'(s_data), 0);
        @(posedge clk); #1;
        check("step_10th_edge", int'(s_data), 1);
        repeat (9) @(posedge clk);
        #1 check("hold_period", int'(s_data), 1);
        @(posedge clk); #1;
        check("step_period", int'(s_data), 2);

        // Wrap: from 9, ten more cycles land on 0 (never 10)
        for (int i = 0; i < 200 && s_data != 20'd9; i++) @(negedge clk);
        check("wait_nine", int'(s_data), 9);
        prev_sign = s_sign;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        check("wrap_zero", int'(s_data), 0);
`ifdef DATA_GEN_SIGN_EN
        check("wrap_sign_toggle", int'(s_sign), int'(~prev_sign));
`else
        check("wrap_sign_zero", int'(s_sign), 0);
`endif

        // Run past three full wraps under the continuous monitor
        repeat (320) @(posedge clk);

        // Mid-run asynchronous reset while data = 5
        for (int i = 0; i < 200 && s_data != 20'd5; i++) @(negedge clk);
        check("wait_five", int'(s_data), 5);
        #3 rst_n = 1'b0;
        #1;
        check("async_data",   int'(s_data),   0);
        check("async_seg_en", int'(s_seg_en), 0);
        check("async_fast",   int'(f_data),   0);
        #2 rst_n = 1'b1;   // released before the next rising edge
        repeat (9) @(posedge clk);
        #1 check("restart_hold", int'(s_data), 0);
        @(posedge clk); #1;
        check("restart_step", int'(s_data), 1);

        // Randomised reset pulses at random points in the count
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 250)) @(posedge clk);
            @(negedge clk);
            #($urandom_range(1, 8)) rst_n = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(negedge clk);
            #2 rst_n = 1'b1;
        end
        repeat (250) @(posedge clk);
        @(negedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
